// File: rtl/at93c46d_seq.sv
// at93c46d_seq: drives the AT93C46D Microwire engine for bulk reads into a word buffer and single-word writes; one word per engine transaction, rd_data 1-cycle latency.
// Requests outside IDLE are dropped (no queueing); `define VERIFY_AFTER_WRITE_EN adds a read-back compare after each write and the verify_err port.
module at93c46d_seq #(
    parameter int N_WORDS        = 64,
    parameter int WR_WAIT_CYCLES = 625000,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read_all,
    input  logic        req_write,
    input  logic [5:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [5:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
`ifdef VERIFY_AFTER_WRITE_EN
    output logic        verify_err,
`endif
    output logic [7:0]  spi_cmd,
    output logic [15:0] spi_data_in,
    output logic        spi_start,
    input  logic        spi_cs,
    input  logic [15:0] spi_data_out
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WW = (WR_WAIT_CYCLES > 1) ? $clog2(WR_WAIT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] W_LAST   = WW'(WR_WAIT_CYCLES - 1);
    localparam logic [5:0]    IDX_LAST = 6'(N_WORDS - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LAUNCH  = 3'd1;
    localparam logic [2:0] WAIT_HI = 3'd2;
    localparam logic [2:0] WAIT_LO = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;
    localparam logic [2:0] WR_WAIT = 3'd6;
    localparam logic [2:0] FINISH  = 3'd7;

    logic [2:0]    state;
    logic          req_rd_q;
    logic          req_wr_q;
    logic          cs_q;
    logic          op_wr;
    logic [5:0]    addr_q;
    logic [15:0]   data_q;
    logic [5:0]    idx;
    logic [TW-1:0] tcnt;
    logic [WW-1:0] wcnt;
    logic [15:0]   buffer [0:N_WORDS-1];
`ifdef VERIFY_AFTER_WRITE_EN
    logic          verify_ph;
`endif

    logic rd_edge;
    logic wr_edge;
    assign rd_edge = req_read_all & ~req_rd_q;
    assign wr_edge = req_write & ~req_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            cs_q        <= 1'b0;
            op_wr       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            idx         <= '0;
            tcnt        <= '0;
            wcnt        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            spi_start   <= 1'b0;
            spi_cmd     <= '0;
            spi_data_in <= '0;
`ifdef VERIFY_AFTER_WRITE_EN
            verify_ph   <= 1'b0;
            verify_err  <= 1'b0;
`endif
        end else begin
            req_rd_q  <= req_read_all;
            req_wr_q  <= req_write;
            cs_q      <= spi_cs;
            spi_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    // Read wins a same-cycle tie; the write edge is simply lost.
                    if (rd_edge || wr_edge) begin
                        op_wr       <= ~rd_edge;
                        addr_q      <= wr_addr;
                        data_q      <= wr_data;
                        idx         <= '0;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
`ifdef VERIFY_AFTER_WRITE_EN
                        verify_ph   <= 1'b0;
                        verify_err  <= 1'b0;
`endif
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    spi_start <= 1'b1;
                    tcnt      <= '0;
                    state     <= WAIT_HI;
                    if (!op_wr) begin
                        spi_cmd <= {2'b10, idx};
                    end
`ifdef VERIFY_AFTER_WRITE_EN
                    else if (verify_ph) begin
                        spi_cmd <= {2'b10, addr_q};
                    end
`endif
                    else begin
                        spi_cmd     <= {2'b01, addr_q};
                        spi_data_in <= data_q;
                    end
                end
                WAIT_HI: begin
                    if (cs_q) begin
                        tcnt  <= tcnt + 1'b1;
                        state <= WAIT_LO;
                    end else if (tcnt == T_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    // The timeout budget spans the whole transaction, not each half.
                    if (!cs_q) begin
                        state <= CAPTURE;
                    end else if (tcnt == T_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CAPTURE: begin
`ifdef VERIFY_AFTER_WRITE_EN
                    if (op_wr && verify_ph) begin
                        if (spi_data_out != data_q) verify_err <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else
`endif
                    if (op_wr) begin
                        wcnt  <= '0;
                        state <= WR_WAIT;
                    end else if (idx == IDX_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= LAUNCH;
                end
                WR_WAIT: begin
                    if (wcnt == W_LAST) begin
`ifdef VERIFY_AFTER_WRITE_EN
                        verify_ph <= 1'b1;
                        state     <= LAUNCH;
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
`endif
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Buffer has no reset; only bulk-read words land here, never write read-backs.
    always_ff @(posedge clk) begin
        if (!rst && state == CAPTURE && !op_wr) begin
            buffer[idx] <= spi_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= buffer[rd_addr];
        end
    end

endmodule

// File: tb/tb_at93c46d_seq.sv
// Directed bench for at93c46d_seq with a behavioural Microwire engine model.
module tb_at93c46d_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read_all;
    logic        req_write;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        timeout_err;
`ifdef VERIFY_AFTER_WRITE_EN
    logic        verify_err;
`endif
    logic [7:0]  spi_cmd;
    logic [15:0] spi_data_in;
    logic        spi_start;
    logic        spi_cs;
    logic [15:0] spi_data_out;

    int vectors     = 0;
    int miscompares = 0;

    int cyc     = 0;
    int n_start = 0;
    int n_done  = 0;
    int t_start = 0;
    int t_done  = 0;

    logic        eng_on   = 1'b1;
    logic        eng_busy = 1'b0;
    logic [15:0] eng_flip = 16'h0000;
    logic [15:0] eng_mem [64];
    logic [7:0]  cmd_log [$];
    logic [15:0] din_log [$];
    int          fall_log [$];

    at93c46d_seq #(
        .N_WORDS        (4),
        .WR_WAIT_CYCLES (100),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_read_all (req_read_all),
        .req_write    (req_write),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
`ifdef VERIFY_AFTER_WRITE_EN
        .verify_err   (verify_err),
`endif
        .spi_cmd      (spi_cmd),
        .spi_data_in  (spi_data_in),
        .spi_start    (spi_start),
        .spi_cs       (spi_cs),
        .spi_data_out (spi_data_out)
    );

    always #5 clk = ~clk;

    // Cycle counter plus start/done monitors, sampled 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (spi_start) begin
                n_start++;
                t_start = cyc;
            end
            if (done) begin
                n_done++;
                t_done = cyc;
            end
        end
    end

    // Engine model: cs rises 2 cycles after start, falls 4 cycles later with data valid.
    initial begin
        spi_cs       = 1'b0;
        spi_data_out = 16'h0000;
        for (int i = 0; i < 64; i++) eng_mem[i] = 16'hA500 + 16'(i);
        forever begin
            @(posedge clk);
            #1;
            if (spi_start && eng_on) begin
                eng_busy = 1'b1;
                cmd_log.push_back(spi_cmd);
                din_log.push_back(spi_data_in);
                repeat (2) @(posedge clk);
                #1 spi_cs = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                if (spi_cmd[7:6] == 2'b10)
                    spi_data_out = eng_mem[spi_cmd[5:0]] ^ eng_flip;
                else
                    eng_mem[spi_cmd[5:0]] = spi_data_in;
                spi_cs = 1'b0;
                fall_log.push_back(cyc);
                eng_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base = n_done;
        int k    = 0;
        while (n_done == base && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(n_done - base), 32'd1);
    endtask

    task automatic pulse_rd();
        req_read_all = 1'b1;
        step(1);
        req_read_all = 1'b0;
    endtask

    task automatic pulse_wr(input logic [5:0] a, input logic [15:0] d);
        wr_addr   = a;
        wr_data   = d;
        req_write = 1'b1;
        step(1);
        req_write = 1'b0;
    endtask

    task automatic check_buf(input string tag, input logic [5:0] a, input logic [15:0] exp);
        rd_addr = a;
        step(1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int s0;
        int c0;
        int f0;
        int k;
        rst          = 1'b1;
        req_read_all = 1'b0;
        req_write    = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        rd_addr      = '0;
        step(3);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        check("rst_start", 32'(spi_start), 32'd0);
        check("rst_cmd", 32'(spi_cmd), 32'h00);
        check("rst_din", 32'(spi_data_in), 32'h0000);
        check("rst_rdata", 32'(rd_data), 32'h0000);

        rst = 1'b0;
        step(2);

        // Bulk read with an extra request pulsed while busy.
        s0 = n_start;
        c0 = cmd_log.size();
        pulse_rd();
        check("rd_busy", 32'(busy), 32'd1);
        step(4);
        pulse_rd();
        wait_done("rd_done", 300);
        check("rd_busy_at_done", 32'(busy), 32'd0);
        check("rd_starts", 32'(n_start - s0), 32'd4);
        for (int i = 0; i < 4; i++) check("rd_cmd", 32'(cmd_log[c0 + i]), 32'h80 + 32'(i));
        step(40);
        check("rd_extra_dropped", 32'(n_start - s0), 32'd4);
        check("rd_done_low", 32'(done), 32'd0);
        check_buf("buf0", 6'd0, 16'hA500);
        check_buf("buf1", 6'd1, 16'hA501);
        check_buf("buf2", 6'd2, 16'hA502);
        check_buf("buf3", 6'd3, 16'hA503);

        // Write: 100 wait cycles; done lands 103 cycles after cs falls (sync + capture + wait).
        c0 = cmd_log.size();
        f0 = fall_log.size();
        pulse_wr(6'h15, 16'h1234);
        wait_done("wr_done", 400);
        check("wr_cmd", 32'(cmd_log[c0]), 32'h55);
        check("wr_din", 32'(din_log[c0]), 32'h1234);
`ifdef VERIFY_AFTER_WRITE_EN
        check("vr_cmd", 32'(cmd_log[c0 + 1]), 32'h95);
        check("vr_latency", 32'(t_done - fall_log[f0 + 1]), 32'd3);
        check("vr_ok", 32'(verify_err), 32'd0);
`else
        check("wr_latency", 32'(t_done - fall_log[f0]), 32'd103);
        check("wr_cmd_hold", 32'(spi_cmd), 32'h55);
`endif
        check_buf("buf0_after_wr", 6'd0, 16'hA500);

        // Silent engine: abort 64 cycles after the start pulse.
        eng_on = 1'b0;
        s0 = n_start;
        pulse_rd();
        wait_done("tmo_done", 300);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_latency", 32'(t_done - t_start), 32'd64);
        check("tmo_starts", 32'(n_start - s0), 32'd1);
        step(2);
        check("tmo_busy", 32'(busy), 32'd0);
        eng_on = 1'b1;
        pulse_wr(6'h20, 16'hBEEF);
        check("tmo_cleared", 32'(timeout_err), 32'd0);
        wait_done("wr2_done", 400);
        check("wr2_no_tmo", 32'(timeout_err), 32'd0);

        // Simultaneous read and write edges: only the read runs.
        step(2);
        s0 = n_start;
        c0 = cmd_log.size();
        wr_addr      = 6'h07;
        wr_data      = 16'h5A5A;
        req_read_all = 1'b1;
        req_write    = 1'b1;
        step(1);
        req_read_all = 1'b0;
        req_write    = 1'b0;
        wait_done("sim_done", 300);
        step(150);
        check("sim_starts", 32'(n_start - s0), 32'd4);
        check("sim_cmd0", 32'(cmd_log[c0]), 32'h80);
        check("sim_cmd3", 32'(cmd_log[c0 + 3]), 32'h83);

        // Reset while the third word (index 2) is in flight.
        s0 = n_start;
        pulse_rd();
        k = 0;
        while ((n_start - s0) < 3 && k < 200) begin
            step(1);
            k++;
        end
        check("mid_reached_idx2", 32'(n_start - s0), 32'd3);
        rst = 1'b1;
        step(1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_start", 32'(spi_start), 32'd0);
        rst = 1'b0;
        k = 0;
        while (eng_busy && k < 50) begin
            step(1);
            k++;
        end
        step(2);
        s0 = n_start;
        pulse_rd();
        wait_done("post_rst_done", 300);
        check("post_rst_starts", 32'(n_start - s0), 32'd4);
        check_buf("post_rst_buf2", 6'd2, 16'hA502);
        check_buf("post_rst_buf3", 6'd3, 16'hA503);

`ifdef VERIFY_AFTER_WRITE_EN
        // Corrupted read-back flags verify_err; a clean one clears it.
        step(2);
        eng_flip = 16'h0001;
        pulse_wr(6'h21, 16'h1234);
        wait_done("vbad_done", 400);
        check("vbad_err", 32'(verify_err), 32'd1);
        eng_flip = 16'h0000;
        pulse_wr(6'h21, 16'h1234);
        check("vgood_cleared", 32'(verify_err), 32'd0);
        wait_done("vgood_done", 400);
        check("vgood_err", 32'(verify_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/at93c46d_seq.md
Name: at93c46d_seq

Overview:
- Command sequencer directly upstream of the AT93C46D Microwire SPI engine.
- Drives the engine's cmd/data_in/start inputs and treats the engine's cs falling edge as transaction completion.
- Supports two operations: bulk read of the EEPROM into an internal word buffer, and single-word write followed by the self-timed write-cycle wait.
- Sits between the register/config interface and the SPI engine.

Parameters:
N_WORDS, 64, number of words fetched by a bulk read, starting at address 0 (1..64)
WR_WAIT_CYCLES, 625000, clk cycles idled after a write (5 ms at 125 MHz)
TIMEOUT_CYCLES, 16384, maximum clk cycles allowed per engine transaction before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_read_all  in  1  rising edge starts a bulk read
req_write  in  1  rising edge starts a single-word write
wr_addr  in  6  write address, sampled on the req_write edge
wr_data  in  16  write data, sampled on the req_write edge
rd_addr  in  6  buffer read address
rd_data  out  16  buffer word at rd_addr, 1-cycle latency
busy  out  1  high from accepted request until done
done  out  1  one-cycle pulse at operation end
timeout_err  out  1  sticky; set on transaction timeout, cleared by next accepted request
spi_cmd  out  8  to engine: [7:6] opcode (10 read, 01 write), [5:0] address
spi_data_in  out  16  to engine: write data
spi_start  out  1  to engine: one-cycle start pulse
spi_cs  in  1  from engine cs
spi_data_out  in  16  from engine data_out

Behaviour:
- Reset values: busy=0, done=0, timeout_err=0, spi_start=0, spi_cmd=0, spi_data_in=0, rd_data=0, state=IDLE. Buffer contents are not reset.
- spi_cs is registered once (cs_q); all completion decisions use cs_q.
- Request edge detection: registered copies of req_read_all and req_write.
  - Requests are accepted only in IDLE; edges arriving outside IDLE are dropped.
  - If both edges occur in the same cycle, the read wins and the write is dropped.
- States:
  - IDLE: on an accepted request, latch the operation, address and data; set busy=1; clear timeout_err; word index=0; go to LAUNCH.
  - LAUNCH: drive spi_cmd/spi_data_in and set spi_start=1 for exactly 1 cycle; clear the timeout counter; go to WAIT_HI.
    - Read: spi_cmd={2'b10, index[5:0]}.
    - Write: spi_cmd={2'b01, wr_addr}, spi_data_in=wr_data.
  - WAIT_HI: wait for cs_q=1, then go to WAIT_LO.
  - WAIT_LO: wait for cs_q=0, then go to CAPTURE.
  - CAPTURE (1 cycle):
    - Read: buffer[index] <= spi_data_out. If index==N_WORDS-1 go to FINISH; else index++, go to GAP.
    - Write: go to WR_WAIT.
  - GAP: 1 idle cycle so spi_start is low for at least 1 cycle between pulses; then go to LAUNCH.
  - WR_WAIT: count WR_WAIT_CYCLES cycles, then go to FINISH.
  - FINISH: done=1 for 1 cycle; busy=0 on the same cycle; return to IDLE.
- spi_cmd and spi_data_in hold their values until the next LAUNCH.
- Timeout: in WAIT_HI or WAIT_LO, if the counter reaches TIMEOUT_CYCLES-1, set timeout_err=1 and go to FINISH (done still pulses). A bulk read aborts at that point: words already captured are kept; the rest keep their old values.
- Buffer read port: rd_data <= buffer[rd_addr] every cycle. Reads with rd_addr>=N_WORDS return an undefined value.
- Counter widths: index 6 bits; timeout and wait counters use $clog2 of their limit.
- Reset mid-operation returns to IDLE within 1 cycle and forces spi_start=0. The engine may still be mid-transaction; the sequencer ignores cs until the next request.

Optional Feature:
VERIFY_AFTER_WRITE_EN
- Defined:
  - After WR_WAIT, the sequencer issues a read of the same address through LAUNCH/WAIT_HI/WAIT_LO.
  - In CAPTURE it compares spi_data_out with wr_data and drives an extra output port verify_err (1 bit, sticky, cleared on the next accepted request) when they differ.
  - The read-back word is not written into the buffer.
  - done pulses after the compare.
- Undefined: the verify_err port is absent, and a write ends after WR_WAIT.

Test Plan:
- Bulk read, N_WORDS=4, engine model returns 16'hA500+addr -> 4 start pulses with spi_cmd 8'h80..8'h83; buffer[0..3]=A500..A503; one done pulse; busy low after.
- Write addr 6'h15, data 16'h1234, WR_WAIT_CYCLES=100 -> spi_cmd=8'h55, spi_data_in=16'h1234; done exactly 100 cycles after cs falls plus FINISH latency.
- Engine model never raises cs, TIMEOUT_CYCLES=64 -> timeout_err=1 and done pulse 64 cycles after LAUNCH; next request clears timeout_err.
- req_read_all pulsed while busy, plus simultaneous read and write edges in IDLE -> extra request ignored; in the simultaneous case only the read executes.
- rst asserted mid bulk read at index 2 -> busy=0 and spi_start=0 next cycle; a new bulk read completes normally.
- With VERIFY_AFTER_WRITE_EN, engine model returns 16'h1235 after a write of 16'h1234 -> verify_err=1; a matching read-back leaves it 0.
